// File: rtl/uart_tx_byte.sv
// UART transmitter: one byte per request, 8 data bits LSB first, 1 or 2 stop bits.
// All outputs are registered; reset aborts any frame and returns the line high.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tx_byte_rdy,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_serial,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             bit_end;

    assign bit_end = (clk_cnt == LAST_CNT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            o_tx_serial <= 1'b1;
            o_tx_busy   <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    o_tx_serial <= 1'b1;
                    o_tx_busy   <= 1'b0;
                    if (i_tx_byte_rdy) begin
                        shift_reg   <= i_tx_byte;
                        state       <= START;
                        o_tx_serial <= 1'b0;
                        o_tx_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt     <= '0;
                        state       <= DATA;
                        o_tx_serial <= shift_reg[0];
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx     <= '0;
                            state       <= STOP;
                            o_tx_serial <= 1'b1;
                        end else begin
                            // Bit 0 sits in shift_reg[0]; the next bit is always one place up.
                            bit_idx     <= bit_idx + 3'd1;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            o_tx_serial <= shift_reg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        // bit_idx is reused to count stop bits.
                        if (bit_idx == LAST_STOP) begin
                            bit_idx   <= '0;
                            state     <= IDLE;
                            o_tx_busy <= 1'b0;
                            o_tx_done <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
